// File: rtl/issue_slot_gen2.sv
// issue_slot_gen2: single issue-queue entry holding one micro-op with two
// tracked source operands, wakeup snooping, select request/grant, kill/clear
// for flush and compaction, and two-phase issue for split micro-ops.
module issue_slot_gen2 #(
  parameter int unsigned NUM_WAKEUP_PORTS = 2,
  parameter int unsigned PREG_W           = 7,
  parameter int unsigned CTRL_W           = 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               in_valid,
  input  logic [PREG_W-1:0]                  in_src1,
  input  logic [PREG_W-1:0]                  in_src2,
  input  logic                               in_p1,
  input  logic                               in_p2,
  input  logic                               in_v1,
  input  logic                               in_v2,
  input  logic                               in_split,
  input  logic [CTRL_W-1:0]                  in_ctrl,
  input  logic [NUM_WAKEUP_PORTS-1:0]        wakeup_valid,
  input  logic [NUM_WAKEUP_PORTS*PREG_W-1:0] wakeup_pdst,
  input  logic                               grant,
  input  logic                               kill,
  input  logic                               clear,
  output logic                               valid,
  output logic                               request,
  output logic                               will_be_valid,
  output logic [PREG_W-1:0]                  slot_src1,
  output logic [PREG_W-1:0]                  slot_src2,
  output logic                               slot_p1,
  output logic                               slot_p2,
  output logic                               slot_v1,
  output logic                               slot_v2,
  output logic [CTRL_W-1:0]                  slot_ctrl,
  output logic                               slot_half,
  output logic [PREG_W-1:0]                  out_src1,
  output logic [PREG_W-1:0]                  out_src2,
  output logic                               out_p1,
  output logic                               out_p2,
  output logic                               out_v1,
  output logic                               out_v2,
  output logic [CTRL_W-1:0]                  out_ctrl,
  output logic                               out_split
);

  typedef enum logic [1:0] {
    S_INVALID = 2'd0,
    S_VALID1  = 2'd1,
    S_VALID2  = 2'd2
  } state_t;

  typedef struct packed {
    logic [PREG_W-1:0] src1;
    logic [PREG_W-1:0] src2;
    logic              p1;
    logic              p2;
    logic              v1;
    logic              v2;
    logic [CTRL_W-1:0] ctrl;
  } uop_t;

  state_t state_q, state_d;
  uop_t   uop_q, uop_d, upd;

  logic is_valid;
  logic wake1, wake2, in_wake1, in_wake2;
  logic rdy1, rdy2;
  logic req;
  logic fire;
  logic load_ok;

  // True when any valid wakeup port broadcasts the given tag.
  function automatic logic tag_match(
    input logic [PREG_W-1:0]                  tag,
    input logic [NUM_WAKEUP_PORTS-1:0]        vld,
    input logic [NUM_WAKEUP_PORTS*PREG_W-1:0] pdst
  );
    logic hit;
    hit = 1'b0;
    for (int unsigned k = 0; k < NUM_WAKEUP_PORTS; k++) begin
      if (vld[k] && (pdst[k*PREG_W +: PREG_W] == tag)) hit = 1'b1;
    end
    return hit;
  endfunction

  // Operand readiness, wakeup snooping and select request.
  always_comb begin
    is_valid = (state_q != S_INVALID);
    wake1    = tag_match(uop_q.src1, wakeup_valid, wakeup_pdst);
    wake2    = tag_match(uop_q.src2, wakeup_valid, wakeup_pdst);
    in_wake1 = tag_match(in_src1, wakeup_valid, wakeup_pdst);
    in_wake2 = tag_match(in_src2, wakeup_valid, wakeup_pdst);
    rdy1     = uop_q.p1 | ~uop_q.v1;
    rdy2     = uop_q.p2 | ~uop_q.v2;
    req      = ((state_q == S_VALID1) && rdy1 && rdy2) ||
               ((state_q == S_VALID2) && rdy1);
    fire     = grant & req;
    load_ok  = in_valid & (~is_valid | clear | kill);
  end

  // Held contents after this cycle's wakeups and grant (compaction view).
  always_comb begin
    upd    = uop_q;
    upd.p1 = uop_q.p1 | (is_valid & wake1);
    upd.p2 = uop_q.p2 | (is_valid & wake2);
    upd.v1 = uop_q.v1 & ~(fire && (state_q == S_VALID2));
  end

  // Next state: load > kill > clear > grant > hold.
  always_comb begin
    state_d = state_q;
    uop_d   = uop_q;
    if (load_ok) begin
      state_d    = in_split ? S_VALID2 : S_VALID1;
      uop_d.src1 = in_src1;
      uop_d.src2 = in_src2;
      uop_d.p1   = in_p1 | in_wake1;
      uop_d.p2   = in_p2 | in_wake2;
      uop_d.v1   = in_v1;
      uop_d.v2   = in_v2;
      uop_d.ctrl = in_ctrl;
    end else if (kill || clear) begin
      state_d = S_INVALID;
    end else begin
      case (state_q)
        S_VALID1: begin
          uop_d = upd;
          if (fire) state_d = S_INVALID;
        end
        S_VALID2: begin
          uop_d = upd;
          if (fire) state_d = S_VALID1;
        end
        default: ;
      endcase
    end
  end

  // State and payload registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_INVALID;
      uop_q   <= '0;
    end else begin
      state_q <= state_d;
      uop_q   <= uop_d;
    end
  end

  // Output mapping.
  always_comb begin
    valid         = is_valid;
    request       = req;
    will_be_valid = is_valid & ~kill & ~clear & ~(fire && (state_q == S_VALID1));
    slot_src1     = uop_q.src1;
    slot_src2     = uop_q.src2;
    slot_p1       = uop_q.p1;
    slot_p2       = uop_q.p2;
    slot_v1       = uop_q.v1;
    slot_v2       = uop_q.v2;
    slot_ctrl     = uop_q.ctrl;
    slot_half     = (state_q == S_VALID2);
    out_src1      = upd.src1;
    out_src2      = upd.src2;
    out_p1        = upd.p1;
    out_p2        = upd.p2;
    out_v1        = upd.v1;
    out_v2        = upd.v2;
    out_ctrl      = upd.ctrl;
    out_split     = (state_q == S_VALID2) & ~fire & ~kill;
  end

  // Dispatch must not overwrite a live entry.
  a_load_busy: assert property (@(posedge clk) disable iff (!reset)
    !(in_valid && is_valid && !clear && !kill));

  // Select may only grant a requesting slot.
  a_grant_req: assert property (@(posedge clk) disable iff (!reset)
    !(grant && !req));

endmodule

// File: tb/tb_issue_slot_gen2.sv
// Bench for issue_slot_gen2: behavioural model checked every cycle for the
// default configuration, plus directed literal checks on a 4-port instance.
module tb_issue_slot_gen2;

  logic clk;
  int   checks = 0;
  int   errors = 0;

  // Default configuration (2 ports, 7-bit tags)
  logic        reset, in_valid, in_p1, in_p2, in_v1, in_v2, in_split;
  logic [6:0]  in_src1, in_src2;
  logic [7:0]  in_ctrl;
  logic [1:0]  wakeup_valid;
  logic [13:0] wakeup_pdst;
  logic        grant, kill, clear;
  logic        valid, request, will_be_valid, slot_p1, slot_p2, slot_v1, slot_v2, slot_half;
  logic [6:0]  slot_src1, slot_src2, out_src1, out_src2;
  logic [7:0]  slot_ctrl, out_ctrl;
  logic        out_p1, out_p2, out_v1, out_v2, out_split;

  // 4-port configuration (8-bit tags)
  logic        d4_reset, d4_in_valid, d4_in_p1, d4_in_p2, d4_in_v1, d4_in_v2, d4_in_split;
  logic [7:0]  d4_in_src1, d4_in_src2, d4_in_ctrl;
  logic [3:0]  d4_wakeup_valid;
  logic [31:0] d4_wakeup_pdst;
  logic        d4_grant, d4_kill, d4_clear;
  logic        d4_valid, d4_request, d4_will_be_valid, d4_slot_p1, d4_slot_p2, d4_slot_v1, d4_slot_v2, d4_slot_half;
  logic [7:0]  d4_slot_src1, d4_slot_src2, d4_out_src1, d4_out_src2, d4_slot_ctrl, d4_out_ctrl;
  logic        d4_out_p1, d4_out_p2, d4_out_v1, d4_out_v2, d4_out_split;

  issue_slot_gen2 dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_src1(in_src1), .in_src2(in_src2),
    .in_p1(in_p1), .in_p2(in_p2), .in_v1(in_v1), .in_v2(in_v2), .in_split(in_split),
    .in_ctrl(in_ctrl), .wakeup_valid(wakeup_valid), .wakeup_pdst(wakeup_pdst),
    .grant(grant), .kill(kill), .clear(clear), .valid(valid), .request(request),
    .will_be_valid(will_be_valid), .slot_src1(slot_src1), .slot_src2(slot_src2),
    .slot_p1(slot_p1), .slot_p2(slot_p2), .slot_v1(slot_v1), .slot_v2(slot_v2),
    .slot_ctrl(slot_ctrl), .slot_half(slot_half), .out_src1(out_src1), .out_src2(out_src2),
    .out_p1(out_p1), .out_p2(out_p2), .out_v1(out_v1), .out_v2(out_v2),
    .out_ctrl(out_ctrl), .out_split(out_split)
  );

  issue_slot_gen2 #(.NUM_WAKEUP_PORTS(4), .PREG_W(8), .CTRL_W(8)) dut4 (
    .clk(clk), .reset(d4_reset), .in_valid(d4_in_valid), .in_src1(d4_in_src1), .in_src2(d4_in_src2),
    .in_p1(d4_in_p1), .in_p2(d4_in_p2), .in_v1(d4_in_v1), .in_v2(d4_in_v2), .in_split(d4_in_split),
    .in_ctrl(d4_in_ctrl), .wakeup_valid(d4_wakeup_valid), .wakeup_pdst(d4_wakeup_pdst),
    .grant(d4_grant), .kill(d4_kill), .clear(d4_clear), .valid(d4_valid), .request(d4_request),
    .will_be_valid(d4_will_be_valid), .slot_src1(d4_slot_src1), .slot_src2(d4_slot_src2),
    .slot_p1(d4_slot_p1), .slot_p2(d4_slot_p2), .slot_v1(d4_slot_v1), .slot_v2(d4_slot_v2),
    .slot_ctrl(d4_slot_ctrl), .slot_half(d4_slot_half), .out_src1(d4_out_src1), .out_src2(d4_out_src2),
    .out_p1(d4_out_p1), .out_p2(d4_out_p2), .out_v1(d4_out_v1), .out_v2(d4_out_v2),
    .out_ctrl(d4_out_ctrl), .out_split(d4_out_split)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model (default configuration) ----------------
  // m_rem = issues still owed by the held op (0 = empty).
  int         m_rem = 0;
  logic [6:0] m_src  [2] = '{7'd0, 7'd0};
  logic       m_p    [2] = '{1'b0, 1'b0};
  logic       m_used [2] = '{1'b0, 1'b0};
  logic [7:0] m_ctrl = 8'd0;
  bit         m_iss;

  function automatic bit woke(input logic [6:0] tag);
    bit h;
    h = 1'b0;
    for (int k = 0; k < 2; k++)
      if (wakeup_valid[k] && (wakeup_pdst[k*7 +: 7] == tag)) h = 1'b1;
    return h;
  endfunction

  function automatic bit m_ready(input int n);
    return m_p[n] || !m_used[n];
  endfunction

  function automatic bit m_req();
    if (m_rem == 2) return m_ready(0);
    if (m_rem == 1) return m_ready(0) && m_ready(1);
    return 1'b0;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_rem = 0;
      for (int n = 0; n < 2; n++) begin
        m_src[n] = 7'd0; m_p[n] = 1'b0; m_used[n] = 1'b0;
      end
      m_ctrl = 8'd0;
    end else begin
      m_iss = grant && m_req();
      if (in_valid && (m_rem == 0 || clear || kill)) begin
        m_rem     = in_split ? 2 : 1;
        m_src[0]  = in_src1;  m_src[1]  = in_src2;
        m_p[0]    = in_p1 || woke(in_src1);
        m_p[1]    = in_p2 || woke(in_src2);
        m_used[0] = in_v1;    m_used[1] = in_v2;
        m_ctrl    = in_ctrl;
      end else if (kill || clear) begin
        m_rem = 0;
      end else if (m_rem > 0) begin
        for (int n = 0; n < 2; n++) if (woke(m_src[n])) m_p[n] = 1'b1;
        if (m_iss) begin
          m_rem = m_rem - 1;
          if (m_rem == 1) m_used[0] = 1'b0;
        end
      end
    end
  end

  // Per-cycle comparison against the model, mid-cycle.
  always @(negedge clk) begin
    bit e_req, e_iss, live;
    e_req = m_req();
    e_iss = grant && e_req;
    live  = (m_rem != 0);
    cmp("valid",         32'(valid),         32'(live));
    cmp("request",       32'(request),       32'(e_req));
    cmp("will_be_valid", 32'(will_be_valid), 32'(live && !kill && !clear && !(e_iss && m_rem == 1)));
    cmp("slot_half",     32'(slot_half),     32'(m_rem == 2));
    cmp("slot_src1",     32'(slot_src1),     32'(m_src[0]));
    cmp("slot_src2",     32'(slot_src2),     32'(m_src[1]));
    cmp("slot_p1",       32'(slot_p1),       32'(m_p[0]));
    cmp("slot_p2",       32'(slot_p2),       32'(m_p[1]));
    cmp("slot_v1",       32'(slot_v1),       32'(m_used[0]));
    cmp("slot_v2",       32'(slot_v2),       32'(m_used[1]));
    cmp("slot_ctrl",     32'(slot_ctrl),     32'(m_ctrl));
    cmp("out_src1",      32'(out_src1),      32'(m_src[0]));
    cmp("out_src2",      32'(out_src2),      32'(m_src[1]));
    cmp("out_p1",        32'(out_p1),        32'(m_p[0] || (live && woke(m_src[0]))));
    cmp("out_p2",        32'(out_p2),        32'(m_p[1] || (live && woke(m_src[1]))));
    cmp("out_v1",        32'(out_v1),        32'(m_used[0] && !(e_iss && m_rem == 2)));
    cmp("out_v2",        32'(out_v2),        32'(m_used[1]));
    cmp("out_ctrl",      32'(out_ctrl),      32'(m_ctrl));
    cmp("out_split",     32'(out_split),     32'(m_rem == 2 && !e_iss && !kill));
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 0; in_src1 = '0; in_src2 = '0; in_p1 = 0; in_p2 = 0; in_v1 = 0; in_v2 = 0;
    in_split = 0; in_ctrl = '0; wakeup_valid = '0; wakeup_pdst = '0;
    grant = 0; kill = 0; clear = 0;
  endtask

  task automatic d4_idle();
    d4_in_valid = 0; d4_in_src1 = '0; d4_in_src2 = '0; d4_in_p1 = 0; d4_in_p2 = 0;
    d4_in_v1 = 0; d4_in_v2 = 0; d4_in_split = 0; d4_in_ctrl = '0;
    d4_wakeup_valid = '0; d4_wakeup_pdst = '0; d4_grant = 0; d4_kill = 0; d4_clear = 0;
  endtask

  task automatic load(input logic [6:0] s1, input logic p1, input logic v1,
                      input logic [6:0] s2, input logic p2, input logic v2,
                      input logic split, input logic [7:0] ctrl);
    in_valid = 1; in_src1 = s1; in_p1 = p1; in_v1 = v1;
    in_src2 = s2; in_p2 = p2; in_v2 = v2; in_split = split; in_ctrl = ctrl;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 0; d4_reset = 0;
    idle(); d4_idle();
    repeat (3) step();
    cmp("rst_valid",   32'(valid),         32'(0));
    cmp("rst_request", 32'(request),       32'(0));
    cmp("rst_wbv",     32'(will_be_valid), 32'(0));
    cmp("rst_src1",    32'(slot_src1),     32'(0));
    reset = 1; d4_reset = 1;

    // Wakeup on port 1 readies src1
    load(7'd5, 0, 1, 7'd9, 1, 1, 0, 8'hA5);
    step(); idle();
    cmp("ld_valid",   32'(valid),     32'(1));
    cmp("ld_request", 32'(request),   32'(0));
    cmp("ld_src2",    32'(slot_src2), 32'(9));
    cmp("ld_ctrl",    32'(slot_ctrl), 32'(8'hA5));
    wakeup_valid = 2'b10; wakeup_pdst = {7'd5, 7'd0};
    #1;
    cmp("wk_out_p1",   32'(out_p1),  32'(1));
    cmp("wk_same_req", 32'(request), 32'(0));
    step(); idle();
    cmp("wk_request", 32'(request), 32'(1));
    grant = 1;
    #1 cmp("gr_wbv", 32'(will_be_valid), 32'(0));
    step(); idle();
    cmp("gr_valid", 32'(valid), 32'(0));

    // Wakeup coinciding with load
    load(7'd3, 0, 1, 7'd0, 0, 0, 0, 8'h11);
    wakeup_valid = 2'b01; wakeup_pdst = {7'd0, 7'd3};
    step(); idle();
    cmp("lw_p1",      32'(slot_p1), 32'(1));
    cmp("lw_request", 32'(request), 32'(1));
    grant = 1; step(); idle();

    // Split micro-op
    load(7'd4, 1, 1, 7'd6, 0, 1, 1, 8'h22);
    step(); idle();
    cmp("sp_half",    32'(slot_half), 32'(1));
    cmp("sp_request", 32'(request),   32'(1));
    grant = 1;
    #1;
    cmp("sp_out_split", 32'(out_split), 32'(0));
    cmp("sp_out_v1",    32'(out_v1),    32'(0));
    step(); idle();
    cmp("sp1_valid", 32'(valid),     32'(1));
    cmp("sp1_half",  32'(slot_half), 32'(0));
    cmp("sp1_v1",    32'(slot_v1),   32'(0));
    cmp("sp1_req",   32'(request),   32'(0));
    wakeup_valid = 2'b01; wakeup_pdst = {7'd0, 7'd6};
    step(); idle();
    cmp("sp2_req", 32'(request), 32'(1));
    grant = 1; step(); idle();
    cmp("sp_done", 32'(valid), 32'(0));

    // Kill beats grant
    load(7'd1, 1, 1, 7'd0, 0, 0, 0, 8'h33);
    step(); idle();
    cmp("kg_req", 32'(request), 32'(1));
    kill = 1; grant = 1;
    #1 cmp("kg_wbv", 32'(will_be_valid), 32'(0));
    step(); idle();
    cmp("kg_valid", 32'(valid), 32'(0));

    // Clear with shift-in; out_* show old op with this cycle's wakeup
    load(7'd7, 0, 1, 7'd8, 0, 1, 0, 8'h3C);
    step(); idle();
    cmp("cl_old_req", 32'(request), 32'(0));
    wakeup_valid = 2'b01; wakeup_pdst = {7'd0, 7'd8};
    clear = 1;
    load(7'd2, 1, 1, 7'd0, 0, 0, 0, 8'h5A);
    #1;
    cmp("cl_out_src1", 32'(out_src1),      32'(7));
    cmp("cl_out_p1",   32'(out_p1),        32'(0));
    cmp("cl_out_p2",   32'(out_p2),        32'(1));
    cmp("cl_out_ctrl", 32'(out_ctrl),      32'(8'h3C));
    cmp("cl_wbv",      32'(will_be_valid), 32'(0));
    step(); idle();
    cmp("cl_src1", 32'(slot_src1), 32'(2));
    cmp("cl_ctrl", 32'(slot_ctrl), 32'(8'h5A));
    cmp("cl_req",  32'(request),   32'(1));
    grant = 1; step(); idle();

    // Tag 0 is an ordinary tag
    load(7'd0, 0, 1, 7'd0, 0, 0, 0, 8'h44);
    step(); idle();
    cmp("t0_req0", 32'(request), 32'(0));
    wakeup_valid = 2'b10; wakeup_pdst = {7'd0, 7'd0};
    step(); idle();
    cmp("t0_req1", 32'(request), 32'(1));
    grant = 1; step(); idle();

    // Reset mid-request, then load on first post-reset edge
    load(7'd1, 1, 1, 7'd0, 0, 0, 0, 8'h55);
    step(); idle();
    cmp("mr_req", 32'(request), 32'(1));
    reset = 0;
    #1;
    cmp("mr_valid", 32'(valid),     32'(0));
    cmp("mr_req0",  32'(request),   32'(0));
    cmp("mr_src1",  32'(slot_src1), 32'(0));
    step();
    reset = 1;
    load(7'd6, 1, 1, 7'd0, 0, 0, 0, 8'h66);
    step(); idle();
    cmp("pr_valid", 32'(valid),   32'(1));
    cmp("pr_req",   32'(request), 32'(1));
    grant = 1; step(); idle();

    // 4-port / 8-bit instance: async reset and per-port matching
    d4_in_valid = 1; d4_in_src1 = 8'h21; d4_in_v1 = 1; d4_in_src2 = 8'h42; d4_in_v2 = 1; d4_in_ctrl = 8'h77;
    step(); d4_idle();
    cmp("d4_valid", 32'(d4_valid),   32'(1));
    cmp("d4_req",   32'(d4_request), 32'(0));
    d4_reset = 0;
    d4_wakeup_valid = 4'b0001; d4_wakeup_pdst = {8'h00, 8'h00, 8'h00, 8'h21};
    #1;
    cmp("d4r_valid", 32'(d4_valid),         32'(0));
    cmp("d4r_req",   32'(d4_request),       32'(0));
    cmp("d4r_wbv",   32'(d4_will_be_valid), 32'(0));
    cmp("d4r_src1",  32'(d4_slot_src1),     32'(0));
    cmp("d4r_ctrl",  32'(d4_slot_ctrl),     32'(0));
    cmp("d4r_osrc1", 32'(d4_out_src1),      32'(0));
    cmp("d4r_op1",   32'(d4_out_p1),        32'(0));
    step();
    d4_reset = 1; d4_idle();
    d4_in_valid = 1; d4_in_src1 = 8'h11; d4_in_v1 = 1; d4_in_src2 = 8'h22; d4_in_v2 = 1;
    step(); d4_idle();
    d4_wakeup_valid = 4'b0001; d4_wakeup_pdst = {8'h22, 8'h22, 8'h11, 8'h33};
    #1;
    cmp("d4_p0_op1", 32'(d4_out_p1), 32'(0));
    cmp("d4_p0_op2", 32'(d4_out_p2), 32'(0));
    step();
    d4_wakeup_valid = 4'b0100; d4_wakeup_pdst = {8'h22, 8'h11, 8'h22, 8'h33};
    #1;
    cmp("d4_p2_op1", 32'(d4_out_p1), 32'(1));
    cmp("d4_p2_op2", 32'(d4_out_p2), 32'(0));
    step();
    cmp("d4_p2_sp1", 32'(d4_slot_p1), 32'(1));
    cmp("d4_p2_req", 32'(d4_request), 32'(0));
    d4_wakeup_valid = 4'b1000; d4_wakeup_pdst = {8'h22, 8'h00, 8'h00, 8'h00};
    step(); d4_idle();
    cmp("d4_p3_sp2", 32'(d4_slot_p2), 32'(1));
    cmp("d4_p3_req", 32'(d4_request), 32'(1));

    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/issue_slot_gen2.md
# issue_slot_gen2

Parametrised single-entry issue-queue slot: holds one micro-op, tracks up to two physical source operands, and snoops N wakeup ports to mark them ready. Raises a request to the select logic, issues on grant, and supports kill/clear for flush and queue compaction. Adds two-phase issue for split micro-ops (store address then store data). Instantiated ISSUE_DEPTH times inside the issue queue, which chains `out_*` of slot i+1 into `in_*` of slot i.

## Interface
- NUM_WAKEUP_PORTS, 2: number of writeback wakeup ports snooped (≥1).
- PREG_W, 7: physical register tag width.
- CTRL_W, 8: width of opaque static control bits (FU type, opcode).
- clk  input  1  clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-low; one clock domain.
- in_valid  input  1  load a new micro-op this cycle.
- in_src1 / in_src2  input  PREG_W each  source physical tags.
- in_p1 / in_p2  input  1 each  source already ready at dispatch.
- in_v1 / in_v2  input  1 each  source is used.
- in_split  input  1  micro-op issues twice (half 1 needs src1, half 2 needs src2).
- in_ctrl  input  CTRL_W  static control info.
- wakeup_valid  input  NUM_WAKEUP_PORTS  per-port valid.
- wakeup_pdst  input  NUM_WAKEUP_PORTS*PREG_W  per-port tag, port k at bits [k*PREG_W +: PREG_W].
- grant  input  1  select logic issued this slot.
- kill  input  1  flush: discard held micro-op.
- clear  input  1  held micro-op has been moved to the next slot down.
- valid  output  1  slot holds a micro-op (registered).
- request  output  1  slot is ready to issue (registered-state derived).
- will_be_valid  output  1  slot still holds a micro-op next cycle absent a load.
- slot_src1, slot_src2, slot_p1, slot_p2, slot_v1, slot_v2, slot_ctrl, slot_half  output  as inputs  current contents; slot_half=1 while first half of a split op pending.
- out_src1 … out_ctrl, out_split  output  as inputs  next-cycle contents (current plus this cycle's wakeups and grant update), for compaction.

## Operation
- State: INVALID, VALID1 (one issue remaining), VALID2 (split op, two issues remaining). valid = state≠INVALID.
- Operand ready: rdyN = pN | ~vN. Wakeup match: wakeup_valid[k] && wakeup_pdst[k]==srcN for any k; sets pN. Tag 0 is a normal tag.
- request = (VALID1 && rdy1 && rdy2) || (VALID2 && rdy1).
- Next-state priority, highest first: load > kill > clear > grant > hold.
  - Load (in_valid): state ← in_split ? VALID2 : VALID1; fields ← in_*; pN ← in_pN | same-cycle wakeup match on in_srcN. Load ignored when valid && !clear && !kill (protocol error, flagged by assertion).
  - kill or clear without load: state ← INVALID.
  - grant && request: VALID1 → INVALID; VALID2 → VALID1 with v1←0 (src1 no longer needed).
  - grant without request: ignored, assertion.
- Wakeups apply every cycle in VALID1/VALID2 unless killed/cleared.
- will_be_valid = valid && !kill && !clear && !(grant && request && state==VALID1).
- out_* reflect updated p bits and v1/out_split after a VALID2 grant; out_split=1 only when next state is VALID2.
- slot_half = (state==VALID2).

## Timing
- Reset (async, reset=0): state INVALID, all field registers 0; valid=0, request=0, will_be_valid=0, slot_*=0, out_*=0.
- Load at cycle t with both sources ready → valid=1, request=1 at t+1; grant at t+1 → valid=0 at t+2.
- Wakeup matching a pending source at cycle t → pN=1 and request (if otherwise ready) at t+1; no same-cycle request.
- Wakeup coinciding with load of matching tag → captured, ready at t+1.
- Split op: request at t+1 (src1 ready), grant → VALID1 at t+2, request again once src2 ready.
- kill and grant same cycle: kill wins, slot INVALID next cycle, issue discarded by downstream.
- clear and in_valid same cycle: new micro-op loaded (compaction shift-in).
- Reset deassertion mid-stream: slot starts INVALID, loads accepted on the first post-reset edge.

## Test plan
- Reset then load src1=5,p1=0,v1=1,src2=9,p2=1,v2=1 → valid=1,request=0; wakeup port1 pdst=5 → request=1 next cycle; grant → valid=0 following cycle.
- Load with src1=3,p1=0 while port0 wakes tag 3 same cycle → slot_p1=1 and request=1 one cycle later.
- Split load src1=4(p1=1),src2=6(p2=0) → slot_half=1,request=1; grant → VALID1, slot_v1=0, request=0; wake 6 → request=1; grant → INVALID.
- Valid slot, kill and grant asserted together → valid=0 next cycle, will_be_valid=0 that cycle.
- clear with in_valid (src1=2,p1=1,v2=0) same cycle → slot holds new op, request=1 next cycle; out_* of prior cycle matched old op with applied wakeups.
- Assert reset low mid-request with NUM_WAKEUP_PORTS=4, PREG_W=8 → all outputs 0 immediately; wakeups on ports 0-3 match only their own tags after release.
